video_timing_gen: RTL



---
 rtl/video_timing_pkg.sv | 23 ++
 rtl/sync_delay_line.sv | 41 ++++
 rtl/video_timing_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: the 640x480@60 mode,
// the counter width, and a helper that sums the four timing segments.
package video_timing_pkg;

   localparam int CNT_W   = 11;
   localparam int FCNT_W  = 16;

   localparam int H_ACTIVE_640 = 640;
   localparam int H_FP_640     = 16;
   localparam int H_SYNC_640   = 96;
   localparam int H_BP_640     = 48;
   localparam int V_ACTIVE_480 = 480;
   localparam int V_FP_480     = 10;
   localparam int V_SYNC_480   = 2;
   localparam int V_BP_480     = 33;

   // Total period of one axis (line or frame) from its four segments.
   function automatic int calc_total(input int active, input int fp,
                                     input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register of configurable depth and width. Depth 0 is a
// plain wire so the caller can ask for zero latency without special-casing.
module sync_delay_line #(
   parameter int               DEPTH   = 1,
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic unused_s;
         assign unused_s = ^{clk, rst_n, en};
         assign dout     = din;
      end else begin : g_shift
         logic [WIDTH-1:0] stage_r [DEPTH];

         // Shift one stage per enabled cycle; every stage resets to the idle value.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage_r[i] <= RST_VAL;
               end
            end else if (en) begin
               stage_r[0] <= din;
               for (int i = 1; i < DEPTH; i++) begin
                  stage_r[i] <= stage_r[i-1];
               end
            end
         end

         assign dout = stage_r[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, frame count, line/frame start
// pulses, and sync/data-enable strobes delayed to line up with downstream
// registered draw stages.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int   H_ACTIVE   = H_ACTIVE_640,
   parameter int   H_FP       = H_FP_640,
   parameter int   H_SYNC     = H_SYNC_640,
   parameter int   H_BP       = H_BP_640,
   parameter int   V_ACTIVE   = V_ACTIVE_480,
   parameter int   V_FP       = V_FP_480,
   parameter int   V_SYNC     = V_SYNC_480,
   parameter int   V_BP       = V_BP_480,
   parameter logic HS_POL     = 1'b0,
   parameter logic VS_POL     = 1'b0,
   parameter int   PIPE_DELAY = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_en,
   output logic [CNT_W-1:0]  o_hcnt,
   output logic [CNT_W-1:0]  o_vcnt,
   output logic              o_hsync,
   output logic              o_vsync,
   output logic              o_de,
   output logic              o_line_start,
   output logic              o_frame_start,
   output logic [FCNT_W-1:0] o_frame_cnt
);

   localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS_C     = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SE_C     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_SS_C     = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SE_C     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   // Bit positions inside the 3-bit strobe bundle carried by the delay line.
   localparam int IDX_HS = 2;
   localparam int IDX_VS = 1;
   localparam int IDX_DE = 0;

   logic [CNT_W-1:0]  hcnt_r;
   logic [CNT_W-1:0]  vcnt_r;
   logic [FCNT_W-1:0] frame_cnt_r;
   logic              line_start_r;
   logic              frame_start_r;
   logic              first_frame_r;
   logic              h_end_s;
   logic              v_end_s;
   logic [2:0]        raw_s;
   logic [2:0]        dly_s;

   // End-of-line / end-of-frame detection and the undelayed, active-high strobes.
   always_comb begin
      h_end_s        = (hcnt_r == H_LAST_C);
      v_end_s        = (vcnt_r == V_LAST_C);
      raw_s          = 3'b000;
      raw_s[IDX_HS]  = (hcnt_r >= H_SS_C) && (hcnt_r < H_SE_C);
      raw_s[IDX_VS]  = (vcnt_r >= V_SS_C) && (vcnt_r < V_SE_C);
      raw_s[IDX_DE]  = (hcnt_r < H_ACT_C) && (vcnt_r < V_ACT_C);
   end

   // Pixel/line counters and completed-frame count; everything holds while disabled.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hcnt_r      <= {CNT_W{1'b0}};
         vcnt_r      <= {CNT_W{1'b0}};
         frame_cnt_r <= {FCNT_W{1'b0}};
      end else if (i_en) begin
         if (h_end_s) begin
            hcnt_r <= {CNT_W{1'b0}};
            if (v_end_s) begin
               vcnt_r      <= {CNT_W{1'b0}};
               frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
               vcnt_r <= vcnt_r + 11'd1;
            end
         end else begin
            hcnt_r <= hcnt_r + 11'd1;
         end
      end
   end

   // Start pulses flag the counter value produced by a wrap. Nothing fires
   // until the first frame after reset has completed, so a partial frame never
   // looks like a real one to downstream consumers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
         first_frame_r <= 1'b1;
      end else if (i_en) begin
         line_start_r  <= h_end_s && (!first_frame_r || v_end_s);
         frame_start_r <= h_end_s && v_end_s;
         if (h_end_s && v_end_s) begin
            first_frame_r <= 1'b0;
         end
      end
   end

   // Strobes are delayed in their active-high form; the idle value is all zeros,
   // and polarity is applied only at the pins. With a depth of 0 the strobes are
   // a pure decode of the counters, so o_de reads high while reset holds (0,0).
   sync_delay_line #(
      .DEPTH   (PIPE_DELAY),
      .WIDTH   (3),
      .RST_VAL (3'b000)
   ) u_sync_delay_line (
      .clk   (clk),
      .rst_n (resetn),
      .en    (i_en),
      .din   (raw_s),
      .dout  (dly_s)
   );

   assign o_hcnt        = hcnt_r;
   assign o_vcnt        = vcnt_r;
   assign o_frame_cnt   = frame_cnt_r;
   assign o_hsync       = dly_s[IDX_HS] ~^ HS_POL;
   assign o_vsync       = dly_s[IDX_VS] ~^ VS_POL;
   assign o_de          = dly_s[IDX_DE];
   assign o_line_start  = line_start_r & i_en;
   assign o_frame_start = frame_start_r & i_en;

endmodule
